// File: rtl/ft600_pkg.sv
// Shared opcodes, response codes and FSM encoding for the FT600 command engine.
package ft600_pkg;

  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ  = 4'h2;
  localparam logic [3:0] RSP_ACK  = 4'hA;
  localparam logic [3:0] RSP_ERR  = 4'hE;
  localparam logic [7:0] TMO_CODE = 8'hFF;

  typedef enum logic [2:0] {
    S_HDR,
    S_ADDR,
    S_WDATA,
    S_ACK,
    S_RHDR,
    S_RDATA
  } state_t;

  function automatic logic [15:0] err_rsp(input logic [7:0] code);
    return {RSP_ERR, 4'h0, code};
  endfunction

endpackage

// File: rtl/ft600_tx_hold.sv
// One-entry skid register in front of the bridge TX FIFO; a word is held
// in tx_in until the FIFO has room, so nothing is lost on tx_full.
module ft600_tx_hold (
  input  logic        ft_clk,
  input  logic        rst,
  input  logic        i_push,
  input  logic [15:0] i_data,
  output logic        o_ready,
  output logic        o_empty,
  input  logic        i_tx_full,
  output logic        o_tx_en,
  output logic [15:0] o_tx_in
);

  logic        r_valid;
  logic [15:0] r_data;

  assign o_tx_en = r_valid & ~i_tx_full;
  assign o_ready = ~r_valid | ~i_tx_full;
  assign o_empty = ~r_valid;
  assign o_tx_in = r_data;

  always_ff @(posedge ft_clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= 16'h0000;
    end else if (i_push && o_ready) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (o_tx_en) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ft600_cmd_engine.sv
// FT600 user-side command engine: pops host packets from the RX FIFO,
// runs register reads/writes and returns responses through the TX FIFO.
//   state   | meaning
//   S_HDR   | idle, pop packet header
//   S_ADDR  | pop start address
//   S_WDATA | pop write data, one reg_we per word
//   S_ACK   | push write ack or error response
//   S_RHDR  | push read header echo
//   S_RDATA | one reg_re at a time, push each read word
module ft600_cmd_engine
  import ft600_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TMO_CYC = 1024
) (
  input  logic              ft_clk,
  input  logic              rst,
  output logic              o_rx_en,
  input  logic [15:0]       i_rx_out,
  input  logic              i_rx_empty,
  output logic              o_tx_en,
  output logic [15:0]       o_tx_in,
  input  logic              i_tx_full,
  output logic [ADDR_W-1:0] o_reg_addr,
  output logic [15:0]       o_reg_wdata,
  output logic              o_reg_we,
  output logic              o_reg_re,
  input  logic [15:0]       i_reg_rdata,
  output logic              o_busy
);

  localparam int TMO_W = $clog2(TMO_CYC + 1);

  state_t            r_state;
  logic [3:0]        r_op;
  logic [11:0]       r_len;
  logic [11:0]       r_rem;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata;
  logic [15:0]       r_rsp;
  logic              r_rx_pend;
  logic              r_reg_we;
  logic              r_reg_re;
  logic              r_rd_pend;
  logic [TMO_W-1:0]  r_tmo;

  logic        w_rx_want;
  logic        w_tmo_zone;
  logic        w_tmo_inc;
  logic        w_tmo_hit;
  logic        w_issue;
  logic        w_push;
  logic [15:0] w_push_data;
  logic        w_tx_rdy;
  logic        w_hold_empty;

  assign w_rx_want = (r_state == S_HDR) || (r_state == S_ADDR) ||
                     ((r_state == S_WDATA) && (r_rem != 12'd0));
  assign o_rx_en   = w_rx_want & ~i_rx_empty & ~r_rx_pend & ~rst;

  // Idle-time counter only runs while the engine is waiting on host data.
  assign w_tmo_zone = (r_state == S_ADDR) || ((r_state == S_WDATA) && (r_rem != 12'd0));
  assign w_tmo_inc  = w_tmo_zone & i_rx_empty & ~r_rx_pend;
  assign w_tmo_hit  = w_tmo_inc && (r_tmo == TMO_W'(TMO_CYC - 1));

  assign w_issue = (r_state == S_RDATA) && (r_rem != 12'd0) && !r_reg_re &&
                   !r_rd_pend && w_hold_empty && !i_tx_full;

  always_comb begin
    w_push      = 1'b0;
    w_push_data = r_rsp;
    case (r_state)
      S_ACK:   w_push = 1'b1;
      S_RHDR: begin
        w_push      = 1'b1;
        w_push_data = {OP_READ, r_len};
      end
      S_RDATA: begin
        w_push      = r_rd_pend;
        w_push_data = i_reg_rdata;
      end
      default: ;
    endcase
  end

  ft600_tx_hold u_tx_hold (
    .ft_clk    (ft_clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_data    (w_push_data),
    .o_ready   (w_tx_rdy),
    .o_empty   (w_hold_empty),
    .i_tx_full (i_tx_full),
    .o_tx_en   (o_tx_en),
    .o_tx_in   (o_tx_in)
  );

  assign o_reg_addr  = r_addr;
  assign o_reg_wdata = r_wdata;
  assign o_reg_we    = r_reg_we;
  assign o_reg_re    = r_reg_re;
  assign o_busy      = (r_state != S_HDR);

  always_ff @(posedge ft_clk) begin
    if (rst) begin
      r_state   <= S_HDR;
      r_op      <= 4'h0;
      r_len     <= 12'd0;
      r_rem     <= 12'd0;
      r_addr    <= '0;
      r_wdata   <= 16'h0000;
      r_rsp     <= 16'h0000;
      r_rx_pend <= 1'b0;
      r_reg_we  <= 1'b0;
      r_reg_re  <= 1'b0;
      r_rd_pend <= 1'b0;
      r_tmo     <= '0;
    end else begin
      r_rx_pend <= o_rx_en;
      r_reg_we  <= 1'b0;
      r_reg_re  <= w_issue;
      r_rd_pend <= r_reg_re;

      if (!w_tmo_zone || o_rx_en || w_tmo_hit) r_tmo <= '0;
      else if (w_tmo_inc)                      r_tmo <= r_tmo + TMO_W'(1);

      // Address advances after each strobe so the strobe cycle sees the current word's address.
      if (r_reg_we || r_reg_re) r_addr <= r_addr + ADDR_W'(1);
      if (r_reg_re)             r_rem  <= r_rem - 12'd1;

      case (r_state)
        S_HDR: begin
          if (r_rx_pend) begin
            r_op  <= i_rx_out[15:12];
            r_len <= i_rx_out[11:0];
            if ((i_rx_out[15:12] == OP_WRITE) || (i_rx_out[15:12] == OP_READ)) begin
              r_state <= S_ADDR;
            end else begin
              r_rsp   <= err_rsp({4'h0, i_rx_out[15:12]});
              r_state <= S_ACK;
            end
          end
        end
        S_ADDR: begin
          if (r_rx_pend) begin
            r_addr <= i_rx_out[ADDR_W-1:0];
            r_rem  <= r_len;
            if (r_op == OP_READ) begin
              r_state <= S_RHDR;
            end else if (r_len == 12'd0) begin
              r_rsp   <= {RSP_ACK, r_len};
              r_state <= S_ACK;
            end else begin
              r_state <= S_WDATA;
            end
          end else if (w_tmo_hit) begin
            r_rsp   <= err_rsp(TMO_CODE);
            r_state <= S_ACK;
          end
        end
        S_WDATA: begin
          if (r_rx_pend) begin
            r_reg_we <= 1'b1;
            r_wdata  <= i_rx_out;
            r_rem    <= r_rem - 12'd1;
          end else if (r_reg_we && (r_rem == 12'd0)) begin
            r_rsp   <= {RSP_ACK, r_len};
            r_state <= S_ACK;
          end else if (w_tmo_hit) begin
            r_rsp   <= err_rsp(TMO_CODE);
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          if (w_tx_rdy) r_state <= S_HDR;
        end
        S_RHDR: begin
          if (w_tx_rdy) r_state <= (r_len == 12'd0) ? S_HDR : S_RDATA;
        end
        S_RDATA: begin
          if ((r_rem == 12'd0) && !r_reg_re && !r_rd_pend && w_hold_empty) r_state <= S_HDR;
        end
        default: r_state <= S_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_ft600_cmd_engine.sv
// Directed bench for ft600_cmd_engine: vector table plus timeout, tx_full and reset sequences.
module tb_ft600_cmd_engine;

  localparam int TMO = 1024;

  logic        ft_clk;
  logic        rst;
  logic        o_rx_en;
  logic [15:0] i_rx_out;
  logic        i_rx_empty;
  logic        o_tx_en;
  logic [15:0] o_tx_in;
  logic        i_tx_full;
  logic [7:0]  o_reg_addr;
  logic [15:0] o_reg_wdata;
  logic        o_reg_we;
  logic        o_reg_re;
  logic [15:0] i_reg_rdata;
  logic        o_busy;

  ft600_cmd_engine #(.ADDR_W(8), .TMO_CYC(TMO)) dut (
    .ft_clk      (ft_clk),
    .rst         (rst),
    .o_rx_en     (o_rx_en),
    .i_rx_out    (i_rx_out),
    .i_rx_empty  (i_rx_empty),
    .o_tx_en     (o_tx_en),
    .o_tx_in     (o_tx_in),
    .i_tx_full   (i_tx_full),
    .o_reg_addr  (o_reg_addr),
    .o_reg_wdata (o_reg_wdata),
    .o_reg_we    (o_reg_we),
    .o_reg_re    (o_reg_re),
    .i_reg_rdata (i_reg_rdata),
    .o_busy      (o_busy)
  );

  initial begin
    ft_clk = 1'b0;
    forever #5 ft_clk = ~ft_clk;
  end

  typedef struct packed {
    int              nw;
    logic [0:4][15:0] w;
    int              ntx;
    logic [0:3][15:0] tx;
    int              nwr;
    logic [0:2][7:0]  wa;
    logic [0:2][15:0] wd;
    int              nrd;
  } vec_t;

  vec_t vt [9];

  logic [15:0] rxq [$];
  logic [15:0] tx_log [$];
  logic [7:0]  wa_log [$];
  logic [15:0] wd_log [$];
  int n_re;
  int n_cmp;
  int n_fail;
  int cyc;
  int tx_cyc;
  int we_cyc;
  bit tx_rand;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endtask

  // Bench-side FIFOs and register model; outputs sampled at negedge, inputs driven 1ns after posedge.
  initial begin
    logic       s_rx_en;
    logic       s_re;
    logic [7:0] s_addr;
    i_rx_out    = 16'h0000;
    i_rx_empty  = 1'b1;
    i_tx_full   = 1'b0;
    i_reg_rdata = 16'h0000;
    cyc = 0;
    forever begin
      @(negedge ft_clk);
      cyc++;
      s_rx_en = o_rx_en;
      s_re    = o_reg_re;
      s_addr  = o_reg_addr;
      if (o_tx_en) begin
        tx_log.push_back(o_tx_in);
        tx_cyc = cyc;
      end
      if (o_reg_we) begin
        wa_log.push_back(o_reg_addr);
        wd_log.push_back(o_reg_wdata);
        we_cyc = cyc;
      end
      if (o_reg_re) begin
        chk("read_outstanding", n_re, tx_log.size() - 1);
        n_re++;
      end
      if (o_tx_en && i_tx_full) bad("tx_en_while_full");
      if (o_reg_we && o_reg_re) bad("we_and_re");
      if (o_rx_en && i_rx_empty) bad("rx_en_while_empty");
      @(posedge ft_clk);
      #1;
      if (s_rx_en && rxq.size() > 0) i_rx_out = rxq.pop_front();
      i_rx_empty  = (rxq.size() == 0);
      i_reg_rdata = s_re ? ({8'h00, s_addr} ^ 16'h5A5A) : 16'h0000;
      i_tx_full   = tx_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic clear_logs();
    tx_log.delete();
    wa_log.delete();
    wd_log.delete();
    n_re = 0;
  endtask

  task automatic wait_idle(input int ntx, input int lim, input string nm);
    int k;
    k = 0;
    while (!(tx_log.size() >= ntx && !o_busy && rxq.size() == 0) && k < lim) begin
      @(negedge ft_clk);
      k++;
    end
    if (k >= lim) bad(nm);
    repeat (8) @(negedge ft_clk);
  endtask

  function automatic logic [15:0] txw(input int i);
    return (i < tx_log.size()) ? tx_log[i] : 16'h0000;
  endfunction

  task automatic run_vec(input int v);
    clear_logs();
    for (int i = 0; i < vt[v].nw; i++) rxq.push_back(vt[v].w[i]);
    wait_idle(vt[v].ntx, 300, $sformatf("v%0d_wait_expired", v));
    chk($sformatf("v%0d_tx_cnt", v), tx_log.size(), vt[v].ntx);
    for (int i = 0; i < vt[v].ntx; i++)
      chk($sformatf("v%0d_tx%0d", v, i), txw(i), vt[v].tx[i]);
    chk($sformatf("v%0d_we_cnt", v), wa_log.size(), vt[v].nwr);
    for (int i = 0; i < vt[v].nwr && i < wa_log.size(); i++) begin
      chk($sformatf("v%0d_wa%0d", v, i), wa_log[i], vt[v].wa[i]);
      chk($sformatf("v%0d_wd%0d", v, i), wd_log[i], vt[v].wd[i]);
    end
    chk($sformatf("v%0d_re_cnt", v), n_re, vt[v].nrd);
    chk($sformatf("v%0d_busy", v), o_busy, 0);
  endtask

  initial begin
    int lat;
    n_cmp   = 0;
    n_fail  = 0;
    n_re    = 0;
    tx_rand = 1'b0;
    rst     = 1'b1;

    vt[0] = '{nw:5, w:{16'h1003, 16'h0010, 16'h0001, 16'h0002, 16'h0003},
              ntx:1, tx:{16'hA003, 48'h0}, nwr:3, wa:{8'h10, 8'h11, 8'h12},
              wd:{16'h0001, 16'h0002, 16'h0003}, nrd:0};
    vt[1] = '{nw:2, w:{16'h2002, 16'h0020, 48'h0},
              ntx:3, tx:{16'h2002, 16'h5A7A, 16'h5A7B, 16'h0}, nwr:0, wa:24'h0,
              wd:48'h0, nrd:2};
    vt[2] = '{nw:1, w:{16'h7000, 64'h0},
              ntx:1, tx:{16'hE007, 48'h0}, nwr:0, wa:24'h0, wd:48'h0, nrd:0};
    vt[3] = '{nw:2, w:{16'h1000, 16'h0033, 48'h0},
              ntx:1, tx:{16'hA000, 48'h0}, nwr:0, wa:24'h0, wd:48'h0, nrd:0};
    vt[4] = '{nw:2, w:{16'h2000, 16'h0040, 48'h0},
              ntx:1, tx:{16'h2000, 48'h0}, nwr:0, wa:24'h0, wd:48'h0, nrd:0};
    vt[5] = '{nw:4, w:{16'h1002, 16'h00FF, 16'hBEEF, 16'h1234, 16'h0},
              ntx:1, tx:{16'hA002, 48'h0}, nwr:2, wa:{8'hFF, 8'h00, 8'h00},
              wd:{16'hBEEF, 16'h1234, 16'h0000}, nrd:0};
    vt[6] = '{nw:1, w:{16'h0005, 64'h0},
              ntx:1, tx:{16'hE000, 48'h0}, nwr:0, wa:24'h0, wd:48'h0, nrd:0};
    vt[7] = '{nw:2, w:{16'h2001, 16'h00FF, 48'h0},
              ntx:2, tx:{16'h2001, 16'h5AA5, 32'h0}, nwr:0, wa:24'h0, wd:48'h0, nrd:1};
    vt[8] = '{nw:3, w:{16'h1001, 16'h1234, 16'h0042, 32'h0},
              ntx:1, tx:{16'hA001, 48'h0}, nwr:1, wa:{8'h34, 16'h0},
              wd:{16'h0042, 32'h0}, nrd:0};

    repeat (3) @(posedge ft_clk);
    @(negedge ft_clk);
    chk("rst_strobes", {27'd0, o_rx_en, o_tx_en, o_reg_we, o_reg_re, o_busy}, 32'd0);
    chk("rst_tx_in", {16'd0, o_tx_in}, 32'd0);
    chk("rst_reg_bus", {8'd0, o_reg_addr, o_reg_wdata}, 32'd0);
    @(posedge ft_clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge ft_clk);

    for (int v = 0; v < 9; v++) run_vec(v);

    // Timeout: WRITE len=4 with only two data words, then the stray words become headers.
    clear_logs();
    rxq.push_back(16'h1004);
    rxq.push_back(16'h0050);
    rxq.push_back(16'h0011);
    rxq.push_back(16'h0022);
    wait_idle(1, TMO + 200, "tmo_wait_expired");
    chk("tmo_tx_cnt", tx_log.size(), 1);
    chk("tmo_rsp", txw(0), 16'hE0FF);
    chk("tmo_we_cnt", wa_log.size(), 2);
    if (wa_log.size() == 2) begin
      chk("tmo_wa0", wa_log[0], 8'h50);
      chk("tmo_wa1", wa_log[1], 8'h51);
    end
    chk("tmo_busy", o_busy, 0);
    lat = tx_cyc - we_cyc;
    chk("tmo_latency_in_range", (lat >= TMO && lat <= TMO + 4), 1);
    clear_logs();
    rxq.push_back(16'h0033);
    rxq.push_back(16'h0044);
    wait_idle(2, 100, "stray_wait_expired");
    chk("stray_tx_cnt", tx_log.size(), 2);
    chk("stray_rsp0", txw(0), 16'hE000);
    chk("stray_rsp1", txw(1), 16'hE000);
    chk("stray_we_cnt", wa_log.size(), 0);

    // READ len=8 with tx_full toggling at random.
    clear_logs();
    tx_rand = 1'b1;
    rxq.push_back(16'h2008);
    rxq.push_back(16'h0080);
    wait_idle(9, 600, "rdfull_wait_expired");
    tx_rand = 1'b0;
    chk("rdfull_tx_cnt", tx_log.size(), 9);
    chk("rdfull_hdr", txw(0), 16'h2008);
    for (int i = 0; i < 8; i++)
      chk($sformatf("rdfull_d%0d", i), txw(i + 1), {8'h00, 8'(8'h80 + i)} ^ 16'h5A5A);
    chk("rdfull_re_cnt", n_re, 8);
    chk("rdfull_busy", o_busy, 0);

    // Reset in the middle of a write burst: packet dropped, no ACK.
    clear_logs();
    rxq.push_back(16'h1003);
    rxq.push_back(16'h0060);
    rxq.push_back(16'h00AA);
    begin
      int k;
      k = 0;
      while (wa_log.size() < 1 && k < 60) begin
        @(negedge ft_clk);
        k++;
      end
      if (k >= 60) bad("midrst_wait_expired");
    end
    repeat (3) @(negedge ft_clk);
    chk("midrst_busy_before", o_busy, 1);
    @(posedge ft_clk);
    #1 rst = 1'b1;
    @(posedge ft_clk);
    @(negedge ft_clk);
    chk("midrst_strobes", {27'd0, o_rx_en, o_tx_en, o_reg_we, o_reg_re, o_busy}, 32'd0);
    chk("midrst_reg_bus", {8'd0, o_reg_addr, o_reg_wdata}, 32'd0);
    chk("midrst_tx_in", {16'd0, o_tx_in}, 32'd0);
    @(posedge ft_clk);
    #1 rst = 1'b0;
    repeat (40) @(negedge ft_clk);
    chk("midrst_no_ack", tx_log.size(), 0);
    chk("midrst_we_cnt", wa_log.size(), 1);
    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
